// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that bursts up to MAX_BURST beats from one requester at a
// time into a FIFO write port; write strobe/data are registered (1-cycle latency).
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_L,
  input  logic [NUM_REQ-1:0]         i_Req_DV,
  input  logic [NUM_REQ*WIDTH-1:0]   i_Req_Data,
  output logic [NUM_REQ-1:0]         o_Req_Ack,
  output logic [NUM_REQ-1:0]         o_Grant,
  input  logic                       i_Fifo_Full,
  output logic                       o_Wr_DV,
  output logic [WIDTH-1:0]           o_Wr_Data,
  output logic [$clog2(NUM_REQ)-1:0] o_Wr_Src
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] RST_PTR   = IW'(NUM_REQ - 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t                          state_q, state_d;
  logic [IW-1:0]                   gidx_q, gidx_d;
  logic [BW-1:0]                   beat_q, beat_d;
  logic [IW-1:0]                   ptr_q, ptr_d;
  logic [NUM_REQ-1:0]              grant_q, grant_d;
  logic                            wr_dv_q, wr_dv_d;
  logic [WIDTH-1:0]                wr_data_q, wr_data_d;
  logic [IW-1:0]                   wr_src_q, wr_src_d;

  logic [NUM_REQ-1:0][WIDTH-1:0]   req_data;
  logic                            arb_vld;
  logic [IW-1:0]                   arb_idx;
  logic [IW-1:0]                   cand;
  logic                            owner_dv;
  logic                            ack;
  logic                            rearb;

  assign req_data = i_Req_Data;

  // Wrap P+k back into 0..NUM_REQ-1; k never exceeds NUM_REQ so one subtract suffices.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  // Search starts just past the last winner, so the previous owner is tried last.
  always_comb begin
    arb_vld = 1'b0;
    arb_idx = ptr_q;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = wrap_idx(ptr_q, k);
      if (!arb_vld && i_Req_DV[cand]) begin
        arb_vld = 1'b1;
        arb_idx = cand;
      end
    end
  end

  assign owner_dv = i_Req_DV[gidx_q];
  assign ack      = (state_q == ST_GRANT) && owner_dv && !i_Fifo_Full;

  always_comb begin
    o_Req_Ack         = '0;
    o_Req_Ack[gidx_q] = ack;
  end

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    beat_d  = beat_q;
    ptr_d   = ptr_q;
    rearb   = 1'b0;

    case (state_q)
      ST_IDLE: rearb = 1'b1;
      ST_GRANT: begin
        if (!owner_dv) begin
          rearb = 1'b1;
        end else if (ack) begin
          if (beat_q == LAST_BEAT) rearb = 1'b1;
          else                     beat_d = beat_q + BW'(1);
        end
        // owner valid but FIFO full: stall with everything held
      end
      default: rearb = 1'b1;
    endcase

    if (rearb) begin
      beat_d = '0;
      if (arb_vld) begin
        state_d = ST_GRANT;
        gidx_d  = arb_idx;
        ptr_d   = arb_idx;
      end else begin
        state_d = ST_IDLE;
      end
    end

    grant_d = '0;
    if (state_d == ST_GRANT) grant_d[gidx_d] = 1'b1;

    wr_dv_d   = ack;
    wr_data_d = ack ? req_data[gidx_q] : wr_data_q;
    wr_src_d  = ack ? gidx_q           : wr_src_q;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= ST_IDLE;
      gidx_q    <= '0;
      beat_q    <= '0;
      ptr_q     <= RST_PTR;
      grant_q   <= '0;
      wr_dv_q   <= 1'b0;
      wr_data_q <= '0;
      wr_src_q  <= '0;
    end else begin
      state_q   <= state_d;
      gidx_q    <= gidx_d;
      beat_q    <= beat_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      wr_dv_q   <= wr_dv_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
    end
  end

  assign o_Grant   = grant_q;
  assign o_Wr_DV   = wr_dv_q;
  assign o_Wr_Data = wr_data_q;
  assign o_Wr_Src  = wr_src_q;

endmodule
